// File: rtl/gate_vector_checker_pkg.sv
// Shared types and the gate truth function for the logic_gates self-check stage.
package gate_chk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        CHECK,
        DONE
    } state_e;

    localparam int GATE_W = 7;
    localparam int G_AND  = 0;
    localparam int G_OR   = 1;
    localparam int G_NOT  = 2;
    localparam int G_NAND = 3;
    localparam int G_NOR  = 4;
    localparam int G_XOR  = 5;
    localparam int G_XNOR = 6;

    function automatic logic [GATE_W-1:0] gate_expected(input logic a, input logic b);
        logic [GATE_W-1:0] e;
        e         = '0;
        e[G_AND]  = a & b;
        e[G_OR]   = a | b;
        e[G_NOT]  = ~a;
        e[G_NAND] = ~(a & b);
        e[G_NOR]  = ~(a | b);
        e[G_XOR]  = a ^ b;
        e[G_XNOR] = ~(a ^ b);
        return e;
    endfunction

endpackage

// File: rtl/gate_vector_checker_if.sv
// Control/status and gate stimulus/observation bundle of the checker.
interface gate_vector_checker_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             abort;
    logic             a;
    logic             b;
    logic [6:0]       gate_obs;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       first_fail_idx;
    logic [6:0]       first_fail_mask;
    logic [1:0]       vec_idx;

    modport master (
        output start, abort, gate_obs,
        input  a, b, busy, done, pass, err_count, first_fail_idx, first_fail_mask, vec_idx
    );

    modport slave (
        input  start, abort, gate_obs,
        output a, b, busy, done, pass, err_count, first_fail_idx, first_fail_mask, vec_idx
    );
endinterface

// File: rtl/gate_vector_checker_ref_model.sv
// Combinational expected gate vector {XNOR,XOR,NOR,NAND,NOT,OR,AND} for given a,b.
module gate_ref_model
    import gate_chk_pkg::*;
(
    input  logic              a_i,
    input  logic              b_i,
    output logic [GATE_W-1:0] exp_o
);
    assign exp_o = gate_expected(a_i, b_i);
endmodule

// File: rtl/gate_vector_checker.sv
// Drives all {a,b} vectors into logic_gates, checks the seven outputs against the
// reference model and reports error count, first failure and pass/fail per run.
module gate_vector_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_LOOPS     = 1,
    parameter int ERR_W         = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    gate_vector_checker_if.slave bus
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int LW = (NUM_LOOPS > 1) ? $clog2(NUM_LOOPS) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [LW-1:0] LOOP_LAST   = LW'(NUM_LOOPS - 1);

    state_e            state_q, state_d;
    logic              a_q, a_d, b_q, b_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [1:0]        vec_q, vec_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [LW-1:0]     loop_q, loop_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [1:0]        ffi_q, ffi_d;
    logic [GATE_W-1:0] ffm_q, ffm_d;
    logic [GATE_W-1:0] exp_vec;
    logic              mismatch;

    gate_ref_model u_ref (
        .a_i   (a_q),
        .b_i   (b_q),
        .exp_o (exp_vec)
    );

    // Written as "match clears mismatch" so unknown observations count as failures.
    always_comb begin
        mismatch = 1'b1;
        if (bus.gate_obs == exp_vec) mismatch = 1'b0;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        loop_d   = loop_q;
        err_d    = err_q;
        ffi_d    = ffi_q;
        ffm_d    = ffm_q;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = APPLY;
                    vec_d   = '0;
                    loop_d  = '0;
                    err_d   = '0;
                    ffi_d   = '0;
                    ffm_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            APPLY: begin
                a_d      = vec_q[1];
                b_d      = vec_q[0];
                settle_d = '0;
                state_d  = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) state_d = CHECK;
                else settle_d = settle_q + 1'b1;
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_q != '1) err_d = err_q + 1'b1;
                    if (err_q == '0) begin
                        ffi_d = {a_q, b_q};
                        ffm_d = bus.gate_obs ^ exp_vec;
                    end
                end
                vec_d   = vec_q + 2'd1;
                state_d = APPLY;
                if (vec_q == 2'd3) begin
                    if (loop_q == LOOP_LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                    end else begin
                        loop_d = loop_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything decided above but keeps the error record.
        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
            a_d     = 1'b0;
            b_d     = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            err_d   = err_q;
            ffi_d   = ffi_q;
            ffm_d   = ffm_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            vec_q    <= '0;
            settle_q <= '0;
            loop_q   <= '0;
            err_q    <= '0;
            ffi_q    <= '0;
            ffm_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            loop_q   <= loop_d;
            err_q    <= err_d;
            ffi_q    <= ffi_d;
            ffm_q    <= ffm_d;
        end
    end

    assign bus.a               = a_q;
    assign bus.b               = b_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.err_count       = err_q;
    assign bus.first_fail_idx  = ffi_q;
    assign bus.first_fail_mask = ffm_q;
    assign bus.vec_idx         = vec_q;

endmodule
